// File: rtl/ping_pong_stepper_pkg.sv
// Shared constants for the ping-pong stepper: direction encoding and default bounds.
// Imported by the top module; rise_detect has no dependencies.
package ping_pong_stepper_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_MIN   = 0;
  localparam int DEF_MAX   = 15;

endpackage

// File: rtl/ping_pong_stepper_rise_detect.sv
// Two-flop sampler that turns a clk-synchronous level into a one-cycle rising-edge pulse.
// rise is combinational from the registers: high for the cycle after d is first seen high.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic r_s0;
  logic r_s1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
    end else begin
      r_s0 <= d;
      r_s1 <= r_s0;
    end
  end

  assign rise = r_s0 & ~r_s1;

endmodule

// File: rtl/ping_pong_stepper.sv
// Bounded up/down counter advanced once per rising edge of a divided-clock waveform sampled on clk.
// A step updates out one edge after tick_src is first sampled high; step strobes alongside that update.
import ping_pong_stepper_pkg::*;

module ping_pong_stepper #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MIN   = DEF_MIN,
  parameter int MAX   = DEF_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_src,
  input  logic             enable,
  input  logic             flip,
  output logic [WIDTH-1:0] out,
  output logic             dir,
  output logic             step
);

  localparam logic [WIDTH-1:0] MIN_V    = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] MIN_P1_V = WIDTH'(MIN + 1);
  localparam logic [WIDTH-1:0] MAX_M1_V = WIDTH'(MAX - 1);
  localparam logic [WIDTH-1:0] ONE_V    = WIDTH'(1);

  logic             w_rise;
  logic             w_take;
  logic             w_ed;
  logic [WIDTH-1:0] r_out;
  logic             r_dir;
  logic             r_flip_pend;
  logic             r_step;

  rise_detect u_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (tick_src),
    .rise  (w_rise)
  );

  assign w_take = w_rise & enable;
  // A flip arriving on the step cycle is folded into that step's direction.
  assign w_ed   = r_dir ^ r_flip_pend ^ flip;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out       <= MIN_V;
      r_dir       <= DIR_UP;
      r_flip_pend <= 1'b0;
      r_step      <= 1'b0;
    end else begin
      r_step <= w_take;
      if (w_take) begin
        r_flip_pend <= 1'b0;
        if (w_ed == DIR_UP) begin
          if (r_out == MAX_V) begin
            r_out <= MAX_M1_V;
            r_dir <= DIR_DOWN;
          end else begin
            r_out <= r_out + ONE_V;
            r_dir <= DIR_UP;
          end
        end else begin
          if (r_out == MIN_V) begin
            r_out <= MIN_P1_V;
            r_dir <= DIR_UP;
          end else begin
            r_out <= r_out - ONE_V;
            r_dir <= DIR_DOWN;
          end
        end
      end else begin
        r_flip_pend <= r_flip_pend ^ flip;
      end
    end
  end

  assign out  = r_out;
  assign dir  = r_dir;
  assign step = r_step;

endmodule

// File: tb/tb_ping_pong_stepper.sv
// Scoreboarded bench for ping_pong_stepper: three instances cover default, 3..5 and 0..1 bounds.
module tb_ping_pong_stepper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_src;
  logic       enable;
  logic       flip;
  logic [3:0] a_out, b_out, c_out;
  logic       a_dir, b_dir, c_dir;
  logic       a_step, b_step, c_step;

  typedef struct packed {
    logic [3:0] out;
    logic       dir;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] stim[$];
  int         checks = 0;
  int         errors = 0;
  int         sel = 0;
  logic [3:0] m_out;
  logic       m_dir;
  logic       m_step;

  ping_pong_stepper dut_a (
    .clk(clk), .rst_n(rst_n), .tick_src(tick_src), .enable(enable), .flip(flip),
    .out(a_out), .dir(a_dir), .step(a_step)
  );

  ping_pong_stepper #(.WIDTH(4), .MIN(3), .MAX(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick_src(tick_src), .enable(enable), .flip(flip),
    .out(b_out), .dir(b_dir), .step(b_step)
  );

  ping_pong_stepper #(.WIDTH(4), .MIN(0), .MAX(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .tick_src(tick_src), .enable(enable), .flip(flip),
    .out(c_out), .dir(c_dir), .step(c_step)
  );

  always #5 clk = ~clk;

  always_comb begin
    m_out  = a_out;
    m_dir  = a_dir;
    m_step = a_step;
    case (sel)
      1: begin m_out = b_out; m_dir = b_dir; m_step = b_step; end
      2: begin m_out = c_out; m_dir = c_dir; m_step = c_step; end
      default: ;
    endcase
  end

  // Inputs change on the falling edge; outputs are observed on the next falling edge.
  task automatic cyc(input logic t, input logic en, input logic f);
    tick_src = t;
    enable   = en;
    flip     = f;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic t, input logic en, input logic f, input int n);
    repeat (n) stim.push_back({t, en, f});
  endtask

  task automatic add_tick();
    add(1'b1, 1'b1, 1'b0, 1);
    add(1'b0, 1'b1, 1'b0, 1);
  endtask

  task automatic expect_step(input int o, input logic d);
    exp_t x;
    x.out = 4'(o);
    x.dir = d;
    sb.push_back(x);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    sb.delete();
    stim.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    checks += 6;
    if (a_out !== 4'd0) begin errors++; $display("FAIL reset_out got %0d want 0", a_out); end
    if (a_dir !== 1'b1) begin errors++; $display("FAIL reset_dir got %0d want 1", a_dir); end
    if (a_step !== 1'b0) begin errors++; $display("FAIL reset_step got %0d want 0", a_step); end
    if (b_out !== 4'd3) begin errors++; $display("FAIL reset_out_b got %0d want 3", b_out); end
    if (b_dir !== 1'b1) begin errors++; $display("FAIL reset_dir_b got %0d want 1", b_dir); end
    if (c_out !== 4'd0) begin errors++; $display("FAIL reset_out_c got %0d want 0", c_out); end
    rst_n = 1'b1;
  endtask

  task automatic test_div2();
    logic [2:0] s;
    exp_t       x;
    int         nsteps = 0;
    sel = 0;
    do_reset();
    for (int i = 1; i <= 15; i++) expect_step(i, 1'b1);
    expect_step(14, 1'b0);
    repeat (16) add_tick();
    while (stim.size() != 0) begin
      s = stim.pop_front();
      cyc(s[2], s[1], s[0]);
      if (m_step) begin
        checks++;
        nsteps++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL div2_step unexpected step out=%0d", m_out);
        end else begin
          x = sb.pop_front();
          if ({m_out, m_dir} !== x) begin
            errors++;
            $display("FAIL div2_step got out=%0d dir=%0d want out=%0d dir=%0d", m_out, m_dir, x.out, x.dir);
          end
        end
      end
    end
    checks++;
    if (nsteps != 16) begin errors++; $display("FAIL div2_count got %0d steps want 16", nsteps); end
  endtask

  task automatic test_div3();
    logic [2:0] s;
    exp_t       x;
    sel = 1;
    do_reset();
    checks++;
    if (b_out !== 4'd3) begin errors++; $display("FAIL div3_start got %0d want 3", b_out); end
    expect_step(4, 1'b1); expect_step(5, 1'b1); expect_step(4, 1'b0);
    expect_step(3, 1'b0); expect_step(4, 1'b1);
    repeat (5) begin
      add(1'b1, 1'b1, 1'b0, 1);
      add(1'b0, 1'b1, 1'b0, 2);
    end
    while (stim.size() != 0) begin
      s = stim.pop_front();
      cyc(s[2], s[1], s[0]);
      if (m_step) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL div3_step unexpected step out=%0d", m_out);
        end else begin
          x = sb.pop_front();
          if ({m_out, m_dir} !== x) begin
            errors++;
            $display("FAIL div3_step got out=%0d dir=%0d want out=%0d dir=%0d", m_out, m_dir, x.out, x.dir);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL div3_missing got %0d unseen steps want 0", sb.size()); end
  endtask

  task automatic test_flip();
    logic [2:0] s;
    exp_t       x;
    sel = 0;
    do_reset();
    for (int i = 1; i <= 7; i++) begin expect_step(i, 1'b1); add_tick(); end
    add(1'b0, 1'b1, 1'b1, 1); add(1'b0, 1'b1, 1'b0, 1); add_tick(); expect_step(6, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1); add_tick(); expect_step(7, 1'b1);
    add(1'b0, 1'b1, 1'b1, 2); add_tick(); expect_step(8, 1'b1);
    add(1'b0, 1'b1, 1'b1, 1); add_tick(); expect_step(7, 1'b0);
    add_tick(); expect_step(6, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1); add_tick(); expect_step(7, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1); add(1'b0, 1'b1, 1'b1, 1); expect_step(6, 1'b0);
    add_tick(); expect_step(5, 1'b0);
    while (stim.size() != 0) begin
      s = stim.pop_front();
      cyc(s[2], s[1], s[0]);
      if (m_step) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL flip_step unexpected step out=%0d", m_out);
        end else begin
          x = sb.pop_front();
          if ({m_out, m_dir} !== x) begin
            errors++;
            $display("FAIL flip_step got out=%0d dir=%0d want out=%0d dir=%0d", m_out, m_dir, x.out, x.dir);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL flip_missing got %0d unseen steps want 0", sb.size()); end
  endtask

  // Continues from out=5, dir=down left by test_flip.
  task automatic test_pause();
    logic [2:0] s;
    exp_t       x;
    sel = 0;
    for (int p = 0; p < 5; p++) begin
      add(1'b1, 1'b0, 1'b0, 1);
      add(1'b0, 1'b0, (p == 2), 1);
    end
    add(1'b1, 1'b0, 1'b0, 2);
    add(1'b1, 1'b1, 1'b0, 2);
    add(1'b0, 1'b1, 1'b0, 1);
    while (stim.size() != 0) begin
      s = stim.pop_front();
      cyc(s[2], s[1], s[0]);
      checks++;
      if (m_step !== 1'b0 || m_out !== 4'd5) begin
        errors++; $display("FAIL pause_hold got out=%0d step=%0d want out=5 step=0", m_out, m_step);
      end
    end
    expect_step(6, 1'b1);
    add_tick();
    while (stim.size() != 0) begin
      s = stim.pop_front();
      cyc(s[2], s[1], s[0]);
      if (m_step) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL pause_step unexpected step out=%0d", m_out);
        end else begin
          x = sb.pop_front();
          if ({m_out, m_dir} !== x) begin
            errors++;
            $display("FAIL pause_step got out=%0d dir=%0d want out=%0d dir=%0d", m_out, m_dir, x.out, x.dir);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL pause_missing got %0d unseen steps want 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] s;
    exp_t       x;
    sel = 0;
    do_reset();
    for (int i = 1; i <= 9; i++) begin expect_step(i, 1'b1); add_tick(); end
    add(1'b1, 1'b1, 1'b0, 1);
    while (stim.size() != 0) begin
      s = stim.pop_front();
      cyc(s[2], s[1], s[0]);
      if (m_step) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rstmid_run unexpected step out=%0d", m_out);
        end else begin
          x = sb.pop_front();
          if ({m_out, m_dir} !== x) begin
            errors++;
            $display("FAIL rstmid_run got out=%0d dir=%0d want out=%0d dir=%0d", m_out, m_dir, x.out, x.dir);
          end
        end
      end
    end
    rst_n = 1'b0;
    cyc(1'b1, 1'b1, 1'b1);
    rst_n = 1'b1;
    checks += 4;
    if (a_out !== 4'd0) begin errors++; $display("FAIL rstmid_out got %0d want 0", a_out); end
    if (a_dir !== 1'b1) begin errors++; $display("FAIL rstmid_dir got %0d want 1", a_dir); end
    if (a_step !== 1'b0) begin errors++; $display("FAIL rstmid_step got %0d want 0", a_step); end
    if (dut_a.r_flip_pend !== 1'b0) begin
      errors++; $display("FAIL rstmid_flip_pend got %0d want 0", dut_a.r_flip_pend);
    end
    add(1'b0, 1'b1, 1'b0, 2);
    add_tick();
    expect_step(1, 1'b1);
    while (stim.size() != 0) begin
      s = stim.pop_front();
      cyc(s[2], s[1], s[0]);
      if (m_step) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rstmid_step_after unexpected step out=%0d", m_out);
        end else begin
          x = sb.pop_front();
          if ({m_out, m_dir} !== x) begin
            errors++;
            $display("FAIL rstmid_step_after got out=%0d dir=%0d want out=%0d dir=%0d", m_out, m_dir, x.out, x.dir);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL rstmid_missing got %0d unseen steps want 0", sb.size()); end
  endtask

  task automatic test_minmax1();
    logic [2:0] s;
    exp_t       x;
    sel = 2;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      expect_step(1, 1'b1); expect_step(0, 1'b0);
      add_tick(); add_tick();
    end
    while (stim.size() != 0) begin
      s = stim.pop_front();
      cyc(s[2], s[1], s[0]);
      checks++;
      if (m_out > 4'd1) begin errors++; $display("FAIL minmax1_range got %0d want <=1", m_out); end
      if (m_step) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL minmax1_step unexpected step out=%0d", m_out);
        end else begin
          x = sb.pop_front();
          if ({m_out, m_dir} !== x) begin
            errors++;
            $display("FAIL minmax1_step got out=%0d dir=%0d want out=%0d dir=%0d", m_out, m_dir, x.out, x.dir);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL minmax1_missing got %0d unseen steps want 0", sb.size()); end
  endtask

  initial begin
    rst_n    = 1'b0;
    tick_src = 1'b0;
    enable   = 1'b0;
    flip     = 1'b0;
    @(negedge clk);
    test_reset();
    test_div2();
    test_div3();
    test_flip();
    test_pause();
    test_reset_mid();
    test_minmax1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
